// File: rtl/apb_gpio_irq.sv
// APB GPIO port: atomic set/clear, per-pin edge/level interrupts with W1C status, PSLVERR on unmapped offsets.
// Optional per-pin input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module apb_gpio_irq #(
    parameter int GPIO_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic [GPIO_WIDTH-1:0] GPIO_OE,
    output logic                  IRQ
);
    typedef logic [GPIO_WIDTH-1:0] vec_t;

    localparam logic [3:0] OFF_DIR      = 4'h0;
    localparam logic [3:0] OFF_DATA_IN  = 4'h1;
    localparam logic [3:0] OFF_DATA_OUT = 4'h2;
    localparam logic [3:0] OFF_OUT_SET  = 4'h3;
    localparam logic [3:0] OFF_OUT_CLR  = 4'h4;
    localparam logic [3:0] OFF_IRQ_EN   = 4'h5;
    localparam logic [3:0] OFF_IRQ_TYPE = 4'h6;
    localparam logic [3:0] OFF_IRQ_POL  = 4'h7;
    localparam logic [3:0] OFF_STATUS   = 4'h8;

    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_width
        $error("apb_gpio_irq: GPIO_WIDTH must be within 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("apb_gpio_irq: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("apb_gpio_irq: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [3:0]            reg_off;
    logic [ADDR_WIDTH-1:0] upper_bits;
    logic                  mapped;
    logic                  access;
    logic                  wr_en;
    vec_t                  wdata;

    vec_t dir_q, data_out_q, irq_en_q, irq_type_q, irq_pol_q, irq_status_q;
    vec_t gpio_out_q, gpio_oe_q;
    logic irq_q;

    vec_t sync_q [SYNC_STAGES];
    vec_t sync_in, filt_in, prev_q;
    vec_t rise, fall, edge_hit, lvl_hit, status_set, status_clr;
    vec_t rd_val;
    logic [31:0] rd_word;

    assign reg_off    = PADDR[5:2];
    assign upper_bits = PADDR >> 6;
    assign mapped     = (upper_bits == '0) && (reg_off <= OFF_STATUS);
    assign access     = PSEL & PENABLE;
    assign wr_en      = access & PWRITE & mapped;
    assign wdata      = PWDATA[GPIO_WIDTH-1:0];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= GPIO_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    // Arm window also covers the filter delay so a pad high at reset never logs an edge.
    localparam int ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

    logic [DB_W-1:0] db_cnt_q [GPIO_WIDTH];
    vec_t            filt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            filt_q <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (sync_in[i] != filt_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        filt_q[i]   <= sync_in[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end
    assign filt_in = filt_q;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    assign filt_in = sync_in;
`endif

    localparam int ARM_W = $clog2(ARM_CYCLES + 1);
    logic [ARM_W-1:0] arm_cnt_q;
    logic             armed;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            arm_cnt_q <= ARM_W'(ARM_CYCLES);
            prev_q    <= '0;
        end else begin
            if (arm_cnt_q != '0) arm_cnt_q <= arm_cnt_q - 1'b1;
            prev_q <= filt_in;
        end
    end
    assign armed = (arm_cnt_q == '0);

    // Status detection is held off until the input pipeline holds real pad samples,
    // otherwise the reset-zero chain would look like an active low level.
    assign rise       = filt_in & ~prev_q;
    assign fall       = ~filt_in & prev_q;
    assign edge_hit   = (irq_pol_q & rise) | (~irq_pol_q & fall);
    assign lvl_hit    = ~(filt_in ^ irq_pol_q);
    assign status_set = armed ? ((irq_type_q & edge_hit) | (~irq_type_q & lvl_hit)) : '0;
    assign status_clr = (wr_en && (reg_off == OFF_STATUS)) ? wdata : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            dir_q        <= '0;
            data_out_q   <= '0;
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
            gpio_out_q   <= '0;
            gpio_oe_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_off)
                    OFF_DIR:      dir_q      <= wdata;
                    OFF_DATA_OUT: data_out_q <= wdata;
                    OFF_OUT_SET:  data_out_q <= data_out_q | wdata;
                    OFF_OUT_CLR:  data_out_q <= data_out_q & ~wdata;
                    OFF_IRQ_EN:   irq_en_q   <= wdata;
                    OFF_IRQ_TYPE: irq_type_q <= wdata;
                    OFF_IRQ_POL:  irq_pol_q  <= wdata;
                    default: ;
                endcase
            end
            // A set on the same cycle as a W1C wins.
            irq_status_q <= (irq_status_q & ~status_clr) | status_set;
            gpio_oe_q    <= dir_q;
            gpio_out_q   <= data_out_q & dir_q;
            irq_q        <= |(irq_status_q & irq_en_q);
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_DIR:      rd_val = dir_q;
            OFF_DATA_IN:  rd_val = filt_in;
            OFF_DATA_OUT: rd_val = data_out_q;
            OFF_IRQ_EN:   rd_val = irq_en_q;
            OFF_IRQ_TYPE: rd_val = irq_type_q;
            OFF_IRQ_POL:  rd_val = irq_pol_q;
            OFF_STATUS:   rd_val = irq_status_q;
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        rd_word = '0;
        rd_word[GPIO_WIDTH-1:0] = rd_val;
    end

    assign PRDATA   = (access && !PWRITE && mapped) ? rd_word : '0;
    assign PSLVERR  = access & ~mapped;
    assign PREADY   = 1'b1;
    assign GPIO_OUT = gpio_out_q;
    assign GPIO_OE  = gpio_oe_q;
    assign IRQ      = irq_q;

endmodule
